return_stack_ctrl: RTL and testbench
====================================

# return_stack_ctrl

Return-address stack controller for the pipelined 19-bit-instruction core. It owns the hardware call stack that backs JSB (push) and RET (pop), driven by the `push`/`pop` strobes the instruction controller decodes. It supplies the top-of-stack return address to the PC mux (`pc_mux = 2'b11`) and reports occupancy and error status. Pipeline stall and flush are handled locally, so the controller never needs to track stack state.

## Interface
- `DEPTH`, 8, number of return-address entries; power of two, ≥ 2
- `ADDR_W`, 12, width of an instruction address
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `push`  in  1  JSB in decode; save `ret_addr_in`
- `pop`  in  1  RET in decode; discard top entry
- `stall`  in  1  pipeline hold; `push`/`pop` ignored while high
- `clear`  in  1  synchronous flush; empties the stack
- `ret_addr_in`  in  ADDR_W  return address (PC+1) to push
- `ret_addr_out`  out  ADDR_W  current top entry; 0 when empty
- `count`  out  $clog2(DEPTH+1)  valid entries
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop attempted while empty

## Operation
- Storage is a circular buffer of DEPTH entries, with write pointer `wptr` (mod DEPTH) and `count`. Top index = (`wptr` − 1) mod DEPTH.
- The effective op is decoded from {`push`,`pop`} only when `stall`=0 and `clear`=0:
  - NOP: no change.
  - PUSH: mem[`wptr`] ← `ret_addr_in`; `wptr`++; `count`++.
  - POP: `wptr`−−; `count`−−.
  - REPLACE (both high): mem[top] ← `ret_addr_in`; `wptr` and `count` unchanged.
- Priority is `clear` > `stall` > op. `clear` sets `count`=0, `wptr`=0, `overflow`=0, `underflow`=0 and does not write mem.
- POP when empty: no state change; `underflow` ← 1.
- REPLACE when empty: behaves as PUSH (count becomes 1); no underflow.
- REPLACE when full: allowed; no overflow.
- PUSH when full: `overflow` ← 1; the data behaviour is set by the macro in Configuration.
- Sticky flags clear only on `reset` or `clear`.
- Mem contents are not reset. `ret_addr_out` is gated to 0 when `empty`.

## Timing
- All state updates on the rising `clk` edge. Outputs are combinational from registers only, with no input-to-output paths.
- `ret_addr_out` during a POP cycle shows the entry being popped. The PC mux consumes it in that same cycle, so RET has zero-cycle latency.
- A pushed value is visible on `ret_addr_out` the cycle after the PUSH edge.
- Reset values: `count`=0, `wptr`=0, `ret_addr_out`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0.
- `reset` asserted mid-operation aborts any op immediately and asynchronously.
- A `clear` coinciding with `push` or `pop` discards the op.
- `stall` held across many cycles freezes all state. Ops resume on the first unstalled edge.

## Configuration
- Macro `RSTACK_WRAP_EN`.
  - Defined: PUSH when full overwrites the oldest entry. mem[`wptr`] ← `ret_addr_in`, `wptr`++, `count` stays DEPTH, and `overflow` ← 1.
  - Undefined: PUSH when full is dropped with no data change. `overflow` ← 1 still applies.
- REPLACE when full is identical in both builds.

## Structure
- Shared package `rstack_pkg`:
  - constants `RSTACK_DEPTH_DEF`=8 and `RSTACK_ADDR_W_DEF`=12
  - enum `rstack_op_t` {`RS_NOP`, `RS_PUSH`, `RS_POP`, `RS_REPLACE`}
- Sub-module `rstack_ram`: DEPTH×ADDR_W register array with one synchronous write port and one asynchronous read port, no reset.
- `return_stack_ctrl` holds the pointer, count and flag logic, and instantiates `rstack_ram`.

## Test plan
- Reset, then PUSH 0x010, 0x020, 0x030 → `count`=3, `ret_addr_out`=0x030. Then three POPs → tops read 0x030, 0x020, 0x010 in their pop cycles, ending with `empty`=1 and `ret_addr_out`=0.
- POP on empty stack → `count` stays 0 and `underflow`=1 from the next cycle. A subsequent PUSH 0x055 leaves `underflow`=1.
- DEPTH=8: nine PUSHes of 0x100..0x108 → `full`=1 and `overflow`=1.
  - Without `RSTACK_WRAP_EN`: top=0x107, and 8 POPs return 0x107..0x100.
  - With it: top=0x108, and 8 POPs return 0x108..0x101.
- PUSH 0x0A0 then push+pop with 0x0B0 → `count`=1, top=0x0B0. push+pop with 0x0C0 on empty → `count`=1, top=0x0C0, `underflow`=0.
- `stall`=1 with push/pop toggling for 4 cycles → no change in `count` or top. `clear` pulsed with push=1 → `count`=0 and flags 0.
- `reset` asserted asynchronously between edges while `count`=5 → all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/rstack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rstack_pkg
// Description : Shared defaults and op encoding for the return-address stack.
// Revision    : 1.0
// ============================================================================
package rstack_pkg;

    localparam int RSTACK_DEPTH_DEF  = 8;
    localparam int RSTACK_ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        RS_NOP     = 2'b00,
        RS_PUSH    = 2'b01,
        RS_POP     = 2'b10,
        RS_REPLACE = 2'b11
    } rstack_op_t;

endpackage
`default_nettype wire

// File: rtl/rstack_ram.sv
`default_nettype none
// ============================================================================
// Module      : rstack_ram
// Description : DEPTH x ADDR_W register array, one synchronous write port and
//               one asynchronous read port, no reset.
// Revision    : 1.0
// ============================================================================
module rstack_ram
    import rstack_pkg::*;
#(
    parameter int DEPTH  = RSTACK_DEPTH_DEF,
    parameter int ADDR_W = RSTACK_ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [ADDR_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [ADDR_W-1:0]        o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/return_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : return_stack_ctrl
// Description : Return-address stack for JSB/RET with occupancy and sticky
//               error flags. Macro RSTACK_WRAP_EN makes a push-when-full
//               overwrite the oldest entry instead of being dropped.
// Revision    : 1.0
// ============================================================================
module return_stack_ctrl
    import rstack_pkg::*;
#(
    parameter int DEPTH  = RSTACK_DEPTH_DEF,
    parameter int ADDR_W = RSTACK_ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       stall,
    input  logic                       clear,
    input  logic [ADDR_W-1:0]          ret_addr_in,
    output logic [ADDR_W-1:0]          ret_addr_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [PTR_W-1:0]  w_wptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_overflow_nxt;
    logic              w_underflow_nxt;
    logic              w_we;
    logic [PTR_W-1:0]  w_waddr;
    logic [PTR_W-1:0]  w_top;
    logic [ADDR_W-1:0] w_rdata;
    logic              w_empty;
    logic              w_full;
    rstack_op_t        w_op;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_max);
    // Power-of-two depth makes the pointer arithmetic wrap for free.
    assign w_top   = r_wptr - c_ptr_one;

    always_comb begin
        w_op = RS_NOP;
        if (!clear && !stall) begin
            w_op = rstack_op_t'({pop, push});
        end
    end

    always_comb begin
        w_wptr_nxt      = r_wptr;
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_we            = 1'b0;
        w_waddr         = r_wptr;

        if (clear) begin
            w_wptr_nxt      = '0;
            w_count_nxt     = '0;
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end else begin
            case (w_op)
                RS_PUSH: begin
                    if (w_full) begin
                        w_overflow_nxt = 1'b1;
`ifdef RSTACK_WRAP_EN
                        w_we       = 1'b1;
                        w_wptr_nxt = r_wptr + c_ptr_one;
`endif
                    end else begin
                        w_we        = 1'b1;
                        w_wptr_nxt  = r_wptr + c_ptr_one;
                        w_count_nxt = r_count + c_cnt_one;
                    end
                end
                RS_POP: begin
                    if (w_empty) begin
                        w_underflow_nxt = 1'b1;
                    end else begin
                        w_wptr_nxt  = r_wptr - c_ptr_one;
                        w_count_nxt = r_count - c_cnt_one;
                    end
                end
                RS_REPLACE: begin
                    // An empty stack has no top to replace, so this acts as a push.
                    w_we = 1'b1;
                    if (w_empty) begin
                        w_wptr_nxt  = r_wptr + c_ptr_one;
                        w_count_nxt = c_cnt_one;
                    end else begin
                        w_waddr = w_top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    rstack_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (ret_addr_in),
        .i_raddr (w_top),
        .o_rdata (w_rdata)
    );

    assign ret_addr_out = w_empty ? '0 : w_rdata;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_stack_ctrl
// Description : Directed self-checking bench for return_stack_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_return_stack_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic              stall;
    logic              clear;
    logic [ADDR_W-1:0] ret_addr_in;
    logic [ADDR_W-1:0] ret_addr_out;
    logic [3:0]        count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int n_cmp;
    int n_err;

    return_stack_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .stall        (stall),
        .clear        (clear),
        .ret_addr_in  (ret_addr_in),
        .ret_addr_out (ret_addr_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic p, input logic q, input logic [ADDR_W-1:0] d);
        push        = p;
        pop         = q;
        ret_addr_in = d;
        step();
        push        = 1'b0;
        pop         = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_top"},   32'(ret_addr_out), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_unf"},   32'(underflow), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_top;
        logic [3:0]        cnt_snap;
        logic [ADDR_W-1:0] top_snap;

        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        push        = 1'b0;
        pop         = 1'b0;
        stall       = 1'b0;
        clear       = 1'b0;
        ret_addr_in = '0;
        step();
        step();
        reset = 1'b0;
        chk_reset_state("rst");

        // Basic LIFO: pushed values come back in reverse, visible in the pop cycle
        do_op(1'b1, 1'b0, 12'h010);
        chk("push1_top", 32'(ret_addr_out), 32'h010);
        do_op(1'b1, 1'b0, 12'h020);
        do_op(1'b1, 1'b0, 12'h030);
        chk("push3_count", 32'(count), 32'd3);
        chk("push3_top", 32'(ret_addr_out), 32'h030);
        pop = 1'b1;
        chk("pop1_top", 32'(ret_addr_out), 32'h030);
        step();
        chk("pop2_top", 32'(ret_addr_out), 32'h020);
        step();
        chk("pop3_top", 32'(ret_addr_out), 32'h010);
        step();
        pop = 1'b0;
        chk("pops_empty", 32'(empty), 32'd1);
        chk("pops_top0", 32'(ret_addr_out), 32'd0);
        chk("pops_unf", 32'(underflow), 32'd0);

        // Underflow is sticky across a later push
        do_op(1'b0, 1'b1, 12'h000);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        do_op(1'b1, 1'b0, 12'h055);
        chk("unf_sticky", 32'(underflow), 32'd1);
        chk("unf_push_top", 32'(ret_addr_out), 32'h055);
        do_clear();
        chk("clr1_count", 32'(count), 32'd0);
        chk("clr1_unf", 32'(underflow), 32'd0);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) begin
            do_op(1'b1, 1'b0, 12'(12'h100 + i));
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
`ifdef RSTACK_WRAP_EN
        exp_top = 12'h108;
`else
        exp_top = 12'h107;
`endif
        chk("ovf_top", 32'(ret_addr_out), 32'(exp_top));
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), 32'(ret_addr_out), 32'(exp_top - 12'(i)));
            step();
        end
        pop = 1'b0;
        chk("ovf_drained", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        chk("clr2_ovf", 32'(overflow), 32'd0);

        // Replace (push+pop together) on a non-empty and an empty stack
        do_op(1'b1, 1'b0, 12'h0A0);
        do_op(1'b1, 1'b1, 12'h0B0);
        chk("rep_count", 32'(count), 32'd1);
        chk("rep_top", 32'(ret_addr_out), 32'h0B0);
        do_op(1'b0, 1'b1, 12'h000);
        chk("rep_pop_empty", 32'(empty), 32'd1);
        do_op(1'b1, 1'b1, 12'h0C0);
        chk("rep_e_count", 32'(count), 32'd1);
        chk("rep_e_top", 32'(ret_addr_out), 32'h0C0);
        chk("rep_e_unf", 32'(underflow), 32'd0);

        // Replace while full leaves count and overflow alone
        for (int i = 0; i < 7; i++) begin
            do_op(1'b1, 1'b0, 12'(12'h200 + i));
        end
        do_op(1'b1, 1'b1, 12'h2EE);
        chk("repf_count", 32'(count), 32'd8);
        chk("repf_top", 32'(ret_addr_out), 32'h2EE);
        chk("repf_ovf", 32'(overflow), 32'd0);
        do_op(1'b0, 1'b1, 12'h000);
        chk("repf_below", 32'(ret_addr_out), 32'h205);

        // Stall freezes everything while push/pop toggle
        cnt_snap = count;
        top_snap = ret_addr_out;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(1'(i), 1'(i >> 1), 12'h3FF);
        end
        chk("stall_count", 32'(count), 32'(cnt_snap));
        chk("stall_top", 32'(ret_addr_out), 32'(top_snap));
        stall = 1'b0;
        do_op(1'b0, 1'b1, 12'h000);
        chk("unstall_pop", 32'(count), 32'(cnt_snap - 4'd1));

        // Clear beats a coincident push and resets sticky flags
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 1'b0, 12'h400);
        end
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        push  = 1'b1;
        clear = 1'b1;
        ret_addr_in = 12'h777;
        step();
        push  = 1'b0;
        clear = 1'b0;
        chk_reset_state("clr3");

        // Asynchronous reset mid-cycle with five entries held
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 1'b0, 12'(12'h500 + i));
        end
        chk("ar_pre_count", 32'(count), 32'd5);
        push = 1'b1;
        ret_addr_in = 12'h5AA;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("arst");
        push = 1'b0;
        step();
        reset = 1'b0;
        chk("arst_hold", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
